// File: rtl/alu_pkg.sv
// alu_pkg: opcode, flag index and FSM state definitions shared by the ALU arbiter slice.
package alu_pkg;
  localparam int NBITS = 5;
  localparam int FLAG_C = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;
  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_NOT = 4'd4,
    OP_XOR = 4'd5,
    OP_SRL = 4'd6,
    OP_SLL = 4'd7,
    OP_SRA = 4'd8,
    OP_SLA = 4'd9
  } op_e;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;
  function automatic logic is_legal(input logic [3:0] op);
    return op <= OP_SLA;
  endfunction
endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response handshakes of both clients plus the shared ALU port.
interface alu_arbiter_if;
  import alu_pkg::*;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [NBITS-1:0] req_a0, req_b0, req_a1, req_b1;
  logic [3:0] req_op0, req_op1;
  logic [1:0] resp_valid;
  logic [1:0] resp_ready;
  logic [NBITS-1:0] resp_out;
  logic [3:0] resp_flags;
  logic resp_err;
  logic [NBITS-1:0] alu_a, alu_b;
  logic [3:0] alu_op;
  logic [NBITS-1:0] alu_out;
  logic [3:0] alu_flags;
  logic busy;
  modport slave (
    input req_valid, req_a0, req_b0, req_a1, req_b1, req_op0, req_op1, resp_ready, alu_out, alu_flags,
    output req_ready, resp_valid, resp_out, resp_flags, resp_err, alu_a, alu_b, alu_op, busy
  );
  modport master (
    output req_valid, req_a0, req_b0, req_a1, req_b1, req_op0, req_op1, resp_ready, alu_out, alu_flags,
    input req_ready, resp_valid, resp_out, resp_flags, resp_err, alu_a, alu_b, alu_op, busy
  );
endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant; last-served pointer advances only when en is high.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       en,
  output logic [1:0] grant
);
  logic last;
  assign grant = (&valid) ? (last ? 2'b01 : 2'b10) : valid;
  always_ff @(posedge clk) begin
    if (rst) last <= 1'b1;
    else if (en) last <= grant[1];
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters, one operation at a time.
module alu_arbiter
  import alu_pkg::*;
(
  input logic clk,
  input logic rst,
  alu_arbiter_if.slave bus
);
  state_e state, state_nx;
  logic [1:0] grant;
  logic accept, owner, err;
  logic [NBITS-1:0] a, b;
  logic [3:0] op, op_sel;
  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .valid (bus.req_valid),
    .en    (accept),
    .grant (grant)
  );
  assign bus.req_ready = (state == IDLE && !rst) ? grant : 2'b00;
  assign accept = |(bus.req_valid & bus.req_ready);
  assign op_sel = grant[1] ? bus.req_op1 : bus.req_op0;
  // Illegal opcodes are stored as 0 so the ALU never sees them, even outside EXEC.
  assign bus.alu_a = a;
  assign bus.alu_b = b;
  assign bus.alu_op = op;
  assign bus.resp_valid = (state == RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;
  assign bus.busy = state != IDLE;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (accept ? EXEC : IDLE) :
               state == EXEC ? RESP :
               (bus.resp_ready[owner] ? IDLE : RESP);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= 1'b0;
      err <= 1'b0;
      a <= '0;
      b <= '0;
      op <= '0;
      bus.resp_out <= '0;
      bus.resp_flags <= '0;
      bus.resp_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        owner <= grant[1];
        a <= grant[1] ? bus.req_a1 : bus.req_a0;
        b <= grant[1] ? bus.req_b1 : bus.req_b0;
        op <= is_legal(op_sel) ? op_sel : 4'd0;
        err <= !is_legal(op_sel);
      end
      if (state == EXEC) begin
        bus.resp_out <= err ? '0 : bus.alu_out;
        bus.resp_flags <= err ? 4'd0 : bus.alu_flags;
        bus.resp_err <= err;
      end
    end
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one combinational ALU between two requesters. Each request carries operands and a 4-bit opcode; the block round-robin arbitrates, registers the winning operands, drives the ALU for one cycle, captures result and flags, and holds the response until the owning requester accepts it. It sits between the ALU and its two clients (instruction path and test/debug port), and is the only block that drives the ALU inputs.

## Interface
- Nbits, 5, operand/result width; equals the ALU's Nbits
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  2  per-requester request valid
- req_ready  out  2  per-requester accept; one-hot or zero
- req_a0, req_b0 / req_a1, req_b1  in  Nbits each  operands of requester 0 / 1
- req_op0 / req_op1  in  4 each  opcode of requester 0 / 1
- resp_valid  out  2  response valid, one-hot to the owning requester
- resp_ready  in  2  per-requester response accept
- resp_out  out  Nbits  registered result, shared bus
- resp_flags  out  4  registered {C,V,Z,N}
- resp_err  out  1  opcode was illegal
- alu_a, alu_b  out  Nbits  ALU operands
- alu_op  out  4  ALU opcode
- alu_out  in  Nbits  ALU result, combinational from alu_a/alu_b/alu_op
- alu_flags  in  4  ALU {C,V,Z,N}, combinational
- busy  out  1  high in any state other than IDLE

## Operation
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOT, 5 XOR, 6 SRL, 7 SLL, 8 SRA, 9 SLA; 10-15 illegal.
- FSM: IDLE -> EXEC -> RESP -> IDLE.
- IDLE: req_ready asserted combinationally to the arbitration winner only. On req_valid&req_ready: latch a, b, op, owner index; go to EXEC.
- Arbitration: round-robin on last-served pointer; pointer resets to 1 so requester 0 wins first. Single valid requester always wins. Pointer updates only on acceptance.
- EXEC: alu_a/alu_b/alu_op driven from latched registers; at clock edge capture alu_out, alu_flags into response registers; go to RESP. Illegal op: alu_op driven 0, captured result 0, flags 0, resp_err 1.
- RESP: resp_valid[owner]=1, outputs stable until resp_ready[owner]; on handshake go to IDLE. resp_ready of the non-owner is ignored.
- Outside EXEC, alu_a/alu_b/alu_op hold the latched values (no glitching toward the ALU); they are 0 after reset.
- Width rules: operands passed unmodified; shift amounts >= Nbits are the ALU's concern; no truncation or extension inside this block.
- Request inputs are sampled only at acceptance; changes afterwards have no effect.

## Timing
- Reset values: req_ready 0 during rst cycle, resp_valid 0, resp_out 0, resp_flags 0, resp_err 0, alu_* 0, busy 0, state IDLE, pointer 1.
- Accept at edge N, ALU evaluated during N+1, resp_valid high from N+2. Minimum 3 cycles between acceptances (resp_ready held high).
- No request accepted while busy; req_ready 0 in EXEC and RESP.
- Simultaneous req_valid in IDLE: grant the requester not served last; loser keeps req_valid and is served next.
- Reset mid-EXEC or mid-RESP: operation dropped, no response, all outputs to reset values next cycle.

## Structure
- Package alu_pkg: opcode enum (4-bit, values above), flag index constants (C=3,V=2,Z=1,N=0), FSM state enum.
- Sub-module rr_arb2: 2-way round-robin grant with pointer register and update enable.
- ALU is instantiated at the parent level, not inside this block.

## Test plan
- Reset then req_valid=01, op0=ADD, a0=3, b0=4 -> req_ready=01 at N, resp_valid=01 at N+2, resp_out=7, flags=0000.
- Both valid continuously, op=SUB 5-5 each, resp_ready=11 -> grants alternate 0,1,0,1; each response resp_out=0, Z=1.
- op0=SLL a0=5'b00011 b0=2, resp_ready held 0 for 5 cycles -> resp_out=5'b01100 stable throughout, no new req_ready until handshake.
- op1=4'b1100 -> resp_valid=10, resp_out=0, resp_flags=0, resp_err=1; alu_op driven 0 during EXEC.
- rst asserted during EXEC -> no resp_valid, next cycle all outputs 0, next request accepted with requester 0 priority.
- resp_ready asserted by non-owner only -> response held, state stays RESP.
